// File: rtl/enc_pkg.sv
// Shared types and widths for the encoder homing / sample scheduling slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enc_pkg;

    localparam int ENC_W = 32;  // encoder position / velocity width
    localparam int OVR_W = 16;  // overrun counter width

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEEK    = 3'd1,
        CAPTURE = 3'd2,
        HOMED   = 3'd3,
        FAULT   = 3'd4
    } home_state_t;

endpackage

// File: rtl/enc_sample_sched.sv
// Fixed-rate snapshot scheduler: a tick every SAMPLE_DIV cycles loads a position/velocity snapshot.
// Latency: snapshot registered on the tick edge; sample_valid rises one cycle after the tick cycle.
// Backpressure: a stalled snapshot is held unchanged; ticks that find it stalled are counted (saturating).
//
// Ports:
//   sys_clk_i, sys_rst_i   clock, synchronous active-high reset
//   pos_i, vel_i, homed_i  live values captured at each tick
//   ready_i / valid_o      consumer handshake
//   pos_o, vel_o, homed_o  held snapshot payload
//   ovr_o                  count of ticks dropped while stalled
module enc_sample_sched
    import enc_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_i,
    input  logic signed [ENC_W-1:0] pos_i,
    input  logic signed [ENC_W-1:0] vel_i,
    input  logic                    homed_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic signed [ENC_W-1:0] pos_o,
    output logic signed [ENC_W-1:0] vel_o,
    output logic                    homed_o,
    output logic [OVR_W-1:0]        ovr_o
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [DIV_W-1:0]        div_q, div_d;
    logic                    vld_q, vld_d;
    logic signed [ENC_W-1:0] pos_q, pos_d;
    logic signed [ENC_W-1:0] vel_q, vel_d;
    logic                    hmd_q, hmd_d;
    logic [OVR_W-1:0]        ovr_q, ovr_d;
    logic                    tick;
    logic                    slot_free;

    assign tick      = (div_q == DIV_W'(SAMPLE_DIV - 1));
    // The slot is free if empty, or if the held snapshot is consumed this very cycle.
    assign slot_free = ~vld_q | ready_i;

    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        vld_d = vld_q;
        pos_d = pos_q;
        vel_d = vel_q;
        hmd_d = hmd_q;
        ovr_d = ovr_q;
        if (tick) begin
            if (slot_free) begin
                vld_d = 1'b1;
                pos_d = pos_i;
                vel_d = vel_i;
                hmd_d = homed_i;
            end else if (ovr_q != '1) begin
                ovr_d = ovr_q + OVR_W'(1);
            end
        end else if (vld_q && ready_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            div_q <= '0;
            vld_q <= 1'b0;
            pos_q <= '0;
            vel_q <= '0;
            hmd_q <= 1'b0;
            ovr_q <= '0;
        end else begin
            div_q <= div_d;
            vld_q <= vld_d;
            pos_q <= pos_d;
            vel_q <= vel_d;
            hmd_q <= hmd_d;
            ovr_q <= ovr_d;
        end
    end

    assign valid_o = vld_q;
    assign pos_o   = pos_q;
    assign vel_o   = vel_q;
    assign homed_o = hmd_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/enc_home_sched.sv
// Encoder index homing sequencer plus home-referenced position and fixed-rate snapshot publishing.
// Latency: cal_pos is enc_pos - offset registered (1 cycle); homed rises 2 cycles after the Z rising edge.
// Backpressure: snapshots use valid/ready; a stalled snapshot is held and dropped ticks are counted.
//
// Ports:
//   sys_clk, sys_rst                 clock, synchronous active-high reset
//   enc_pos, enc_vel, enc_z          raw encoder position/velocity and filtered index level
//   home_start, home_abort           single-cycle homing commands (abort wins)
//   home_busy, homed, home_err       homing status (SEEK|CAPTURE, HOMED, FAULT)
//   cal_pos                          home-referenced position
//   sample_valid/ready, sample_*     snapshot handshake and payload
//   overrun_cnt                      saturating count of ticks dropped while stalled
module enc_home_sched
    import enc_pkg::*;
#(
    parameter int                    SAMPLE_DIV  = 50000,
    parameter int                    TIMEOUT_CYC = 100000000,
    parameter logic signed [ENC_W-1:0] HOME_OFS  = '0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic signed [ENC_W-1:0] enc_pos,
    input  logic signed [ENC_W-1:0] enc_vel,
    input  logic                    enc_z,
    input  logic                    home_start,
    input  logic                    home_abort,
    output logic                    home_busy,
    output logic                    homed,
    output logic                    home_err,
    output logic signed [ENC_W-1:0] cal_pos,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic signed [ENC_W-1:0] sample_pos,
    output logic signed [ENC_W-1:0] sample_vel,
    output logic                    sample_homed,
    output logic [OVR_W-1:0]        overrun_cnt
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    home_state_t             state_q;
    logic [TMO_W-1:0]        tmo_q;
    logic                    z_q;
    logic signed [ENC_W-1:0] idx_q;
    logic signed [ENC_W-1:0] ofs_q;
    logic signed [ENC_W-1:0] cal_q;
    logic                    busy_q;
    logic                    homed_q;
    logic                    err_q;
    logic                    z_rise;
    logic                    tmo_hit;

    assign z_rise  = enc_z & ~z_q;
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Homing FSM; status outputs are registered alongside the state so they
    // change in the same cycle as the state they describe.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            z_q     <= 1'b0;
            idx_q   <= '0;
            ofs_q   <= '0;
            cal_q   <= '0;
            busy_q  <= 1'b0;
            homed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            z_q   <= enc_z;
            // Wraps modulo 2^32 by construction.
            cal_q <= enc_pos - ofs_q;

            case (state_q)
                IDLE, HOMED, FAULT: begin
                    // A coincident abort cancels the start outside of homing.
                    if (home_start && !home_abort) begin
                        state_q <= SEEK;
                        tmo_q   <= '0;
                        busy_q  <= 1'b1;
                        homed_q <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                SEEK: begin
                    if (home_abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (z_rise) begin
                        // Index edge takes priority over a coincident timeout.
                        idx_q   <= enc_pos;
                        state_q <= CAPTURE;
                    end else if (tmo_hit) begin
                        state_q <= FAULT;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                CAPTURE: begin
                    if (home_abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        ofs_q   <= idx_q - HOME_OFS;
                        state_q <= HOMED;
                        busy_q  <= 1'b0;
                        homed_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    homed_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign home_busy = busy_q;
    assign homed     = homed_q;
    assign home_err  = err_q;
    assign cal_pos   = cal_q;

    enc_sample_sched #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_sched (
        .sys_clk_i (sys_clk),
        .sys_rst_i (sys_rst),
        .pos_i     (cal_q),
        .vel_i     (enc_vel),
        .homed_i   (homed_q),
        .ready_i   (sample_ready),
        .valid_o   (sample_valid),
        .pos_o     (sample_pos),
        .vel_o     (sample_vel),
        .homed_o   (sample_homed),
        .ovr_o     (overrun_cnt)
    );

endmodule

// File: tb/tb_enc_home_sched.sv
module tb_enc_home_sched;

    localparam int SD = 8;
    localparam int TC = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] enc_pos, enc_vel;
    logic        enc_z, home_start, home_abort, sample_ready;

    logic        home_busy, homed, home_err, sample_valid, sample_homed;
    logic [31:0] cal_pos, sample_pos, sample_vel;
    logic [15:0] overrun_cnt;

    // Second instance with a nonzero home offset, same stimulus.
    logic        b_busy, b_homed, b_err, b_vld, b_shomed;
    logic [31:0] b_cal, b_pos, b_vel;
    logic [15:0] b_ovr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    enc_home_sched #(.SAMPLE_DIV(SD), .TIMEOUT_CYC(TC), .HOME_OFS(32'sd0)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enc_pos(enc_pos), .enc_vel(enc_vel),
        .enc_z(enc_z), .home_start(home_start), .home_abort(home_abort),
        .home_busy(home_busy), .homed(homed), .home_err(home_err), .cal_pos(cal_pos),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_pos(sample_pos),
        .sample_vel(sample_vel), .sample_homed(sample_homed), .overrun_cnt(overrun_cnt)
    );

    enc_home_sched #(.SAMPLE_DIV(SD), .TIMEOUT_CYC(TC), .HOME_OFS(32'sd100)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enc_pos(enc_pos), .enc_vel(enc_vel),
        .enc_z(enc_z), .home_start(home_start), .home_abort(home_abort),
        .home_busy(b_busy), .homed(b_homed), .home_err(b_err), .cal_pos(b_cal),
        .sample_valid(b_vld), .sample_ready(sample_ready), .sample_pos(b_pos),
        .sample_vel(b_vel), .sample_homed(b_shomed), .overrun_cnt(b_ovr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Inputs are driven at the falling edge; outputs are read at the next falling edge.
    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    typedef struct {
        logic        start;
        logic        abort;
        logic        z;
        logic [31:0] pos;
        logic        busy;
        logic        hmd;
        logic        err;
        logic [31:0] cal;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int cnt;
        int first_idx;
        logic found;

        // start abort z    pos   | busy homed err cal
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'd990,  1'b1, 1'b0, 1'b0, 32'd990};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 32'd995,  1'b1, 1'b0, 1'b0, 32'd995};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'd1000, 1'b1, 1'b0, 1'b0, 32'd1000};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 32'd1002, 1'b0, 1'b1, 1'b0, 32'd1002};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 32'd1005, 1'b0, 1'b1, 1'b0, 32'd5};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 32'd1005, 1'b1, 1'b0, 1'b0, 32'd5};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 32'd1010, 1'b1, 1'b0, 1'b0, 32'd10};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'd1010, 1'b0, 1'b0, 1'b0, 32'd10};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 32'd1020, 1'b0, 1'b0, 1'b0, 32'd20};

        sys_rst = 1'b1; enc_pos = 32'd123; enc_vel = 32'd7; enc_z = 1'b0;
        home_start = 1'b0; home_abort = 1'b0; sample_ready = 1'b1;
        @(negedge sys_clk);
        step();
        step();

        // Reset state
        chk1("rst_busy", home_busy, 1'b0);
        chk1("rst_homed", homed, 1'b0);
        chk1("rst_err", home_err, 1'b0);
        chk("rst_cal", cal_pos, 32'd0);
        chk1("rst_valid", sample_valid, 1'b0);
        chk("rst_spos", sample_pos, 32'd0);
        chk("rst_svel", sample_vel, 32'd0);
        chk1("rst_shomed", sample_homed, 1'b0);
        chk("rst_ovr", {16'd0, overrun_cnt}, 32'd0);

        // Idle sampling: one snapshot per SD cycles, first on the SD-th edge.
        sys_rst = 1'b0;
        cnt = 0; first_idx = 0;
        for (int i = 1; i <= 3 * SD; i++) begin
            step();
            if (sample_valid) begin
                cnt++;
                if (cnt == 1) first_idx = i;
                chk("idle_spos", sample_pos, 32'd123);
                chk1("idle_shomed", sample_homed, 1'b0);
            end
        end
        chk("idle_tick_count", cnt, 32'd3);
        chk("idle_first_tick", first_idx, SD);
        chk("idle_ovr", {16'd0, overrun_cnt}, 32'd0);
        chk1("idle_homed", homed, 1'b0);

        // Homing, restart while busy, abort tie-breaks (table driven).
        for (int i = 0; i < 9; i++) begin
            home_start = tbl[i].start;
            home_abort = tbl[i].abort;
            enc_z      = tbl[i].z;
            enc_pos    = tbl[i].pos;
            step();
            chk1($sformatf("vec%0d_busy", i), home_busy, tbl[i].busy);
            chk1($sformatf("vec%0d_homed", i), homed, tbl[i].hmd);
            chk1($sformatf("vec%0d_err", i), home_err, tbl[i].err);
            chk($sformatf("vec%0d_cal", i), cal_pos, tbl[i].cal);
            if (i == 4) begin
                chk("ofs_cal", b_cal, 32'd105);
                chk1("ofs_homed", b_homed, 1'b1);
                chk1("ofs_busy", b_busy, 1'b0);
                chk1("ofs_err", b_err, 1'b0);
            end
        end
        home_start = 1'b0; home_abort = 1'b0;

        // Timeout: FAULT exactly TC edges after entering SEEK.
        home_start = 1'b1;
        step();
        home_start = 1'b0;
        chk1("tmo_seek", home_busy, 1'b1);
        repeat (TC - 1) step();
        chk1("tmo_early_err", home_err, 1'b0);
        chk1("tmo_early_busy", home_busy, 1'b1);
        step();
        chk1("tmo_fault_err", home_err, 1'b1);
        chk1("tmo_fault_busy", home_busy, 1'b0);

        // Restart from FAULT, then Z rises on the timeout cycle.
        home_start = 1'b1;
        step();
        home_start = 1'b0;
        chk1("restart_err", home_err, 1'b0);
        chk1("restart_busy", home_busy, 1'b1);
        repeat (TC - 1) step();
        enc_z = 1'b1; enc_pos = 32'd2;
        step();
        chk1("tie_busy", home_busy, 1'b1);
        chk1("tie_err", home_err, 1'b0);
        enc_pos = 32'd3;
        step();
        chk1("tie_homed", homed, 1'b1);

        // Wrap: offset is 2.
        enc_pos = 32'h8000_0001;
        step();
        chk("wrap_cal", cal_pos, 32'h7FFF_FFFF);

        // Next snapshot carries homed.
        found = 1'b0;
        for (int i = 0; i < 2 * SD && !found; i++) begin
            step();
            if (sample_valid) found = 1'b1;
        end
        chk1("homed_sample_seen", found, 1'b1);
        if (found) begin
            chk1("homed_sample_flag", sample_homed, 1'b1);
            chk("homed_sample_pos", sample_pos, 32'h7FFF_FFFF);
        end

        // Reset in the middle of SEEK loses the offset.
        enc_z = 1'b0;
        step();
        home_start = 1'b1;
        step();
        home_start = 1'b0;
        sys_rst = 1'b1;
        step();
        chk1("midrst_busy", home_busy, 1'b0);
        chk1("midrst_homed", homed, 1'b0);
        chk("midrst_cal", cal_pos, 32'd0);
        chk1("midrst_valid", sample_valid, 1'b0);
        sys_rst = 1'b0; enc_pos = 32'd50;
        step();
        chk("midrst_ofs_lost", cal_pos, 32'd50);

        // Backpressure: 4 ticks with ready low.
        sys_rst = 1'b1; enc_pos = 32'd777; enc_vel = 32'd55; sample_ready = 1'b0;
        step();
        step();
        sys_rst = 1'b0;
        repeat (SD - 1) step();
        chk1("bp_before_tick", sample_valid, 1'b0);
        step();
        chk1("bp_first_valid", sample_valid, 1'b1);
        enc_pos = 32'd888; enc_vel = 32'd66;
        repeat (3 * SD) step();
        chk1("bp_valid_held", sample_valid, 1'b1);
        chk("bp_pos_held", sample_pos, 32'd777);
        chk("bp_vel_held", sample_vel, 32'd55);
        chk("bp_ovr", {16'd0, overrun_cnt}, 32'd3);
        chk1("bp2_valid", b_vld, 1'b1);
        chk("bp2_pos", b_pos, 32'd777);
        chk("bp2_vel", b_vel, 32'd55);
        chk1("bp2_shomed", b_shomed, 1'b0);
        chk("bp2_ovr", {16'd0, b_ovr}, 32'd3);
        sample_ready = 1'b1;
        step();
        chk1("bp_valid_drop", sample_valid, 1'b0);

        // Saturation of the overrun counter.
        sample_ready = 1'b0;
        force dut.u_sched.ovr_q = 16'hFFFD;
        step();
        release dut.u_sched.ovr_q;
        repeat (5 * SD) step();
        chk("ovr_saturate", {16'd0, overrun_cnt}, 32'h0000_FFFF);
        chk1("ovr_valid_held", sample_valid, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
